// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART MMIO register bank.
// Register offsets, I/O region tag and error flag bit positions.
package uart_mmio_pkg;

  localparam logic [3:0] IO_REGION   = 4'b1000;

  localparam logic [7:0] OFF_TX_STAT = 8'h00;
  localparam logic [7:0] OFF_RX_STAT = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_RX_DATA = 8'h0C;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_ERR     = 8'h14;

  localparam int ERR_TX_DROP = 0;
  localparam int ERR_RX_OVR  = 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO buffering received UART data until software pops it.
// Occupancy count carries one extra bit so full and empty are distinct.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = cnt_q == CNT_FULL;
  assign empty   = cnt_q == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only slots behind the count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// UART memory-mapped register bank: TX holding register, RX FIFO,
// sticky error flags and a software-readable cycle counter.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_uart,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  byte_offset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic [31:0]      rdata_q, rdata_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             ovr_q, ovr_d;

  logic       acc, wr, rd;
  logic [7:0] off;
  logic       tx_hs, tx_wr, tx_acc;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic       err_clr;
  logic [31:0] rd_val;
  logic       unused_bits;

  assign unused_bits = ^{mem_addr[31:8], mem_addr[1:0], wdata[31:8]};

  assign off = {mem_addr[7:2], 2'b00};
  assign acc = is_uart & (byte_offset == 2'b00);
  assign wr  = acc & wr_en;
  assign rd  = acc & rd_en & ~wr_en;

  assign tx_hs   = tx_valid_q & tx_ready;
  assign tx_wr   = wr & (off == OFF_TX_DATA);
  assign tx_acc  = tx_wr & (~tx_valid_q | tx_hs);
  assign rx_push = rx_valid & rx_ready;
  assign rx_pop  = rd & (off == OFF_RX_DATA) & ~rx_empty;
  assign err_clr = wr & (off == OFF_ERR);

  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      off == OFF_TX_STAT: rd_val = {31'b0, ~tx_valid_q};
      off == OFF_RX_STAT: rd_val = {31'b0, ~rx_empty};
      off == OFF_RX_DATA: rd_val = rx_empty ? '0 : {24'b0, rx_head};
      off == OFF_CYCLE:   rd_val = 32'(cnt_q);
      off == OFF_ERR:     rd_val = {30'b0, ovr_q, drop_q};
      default:            rd_val = '0;
    endcase
  end

  // Sets win over write-1-clears landing in the same cycle.
  always_comb begin
    rdata_d    = rd ? rd_val : rdata_q;
    tx_valid_d = tx_acc | (tx_valid_q & ~tx_hs);
    tx_data_d  = tx_acc ? wdata[7:0] : tx_data_q;
    cnt_d      = (wr & (off == OFF_CYCLE)) ? '0 : cnt_q + CNT_W'(1);
    drop_d     = (drop_q & ~(err_clr & wdata[ERR_TX_DROP]))
               | (tx_wr & ~tx_acc);
    ovr_d      = (ovr_q & ~(err_clr & wdata[ERR_RX_OVR]))
               | (rx_valid & rx_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rdata    = rdata_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign rx_ready = ~rx_full;

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: directed scenarios plus random traffic
// against a queue-level model, on a default and a small-parameter instance.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_uart = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  byte_offset = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  logic [31:0] rdata_w [2];
  logic [7:0]  txd_w [2];
  logic        txv_w [2];
  logic        rxr_w [2];

  always #5 clk = ~clk;

  uart_mmio #(.RX_DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .is_uart(is_uart), .mem_addr(mem_addr),
    .byte_offset(byte_offset), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata_w[0]), .tx_data(txd_w[0]),
    .tx_valid(txv_w[0]), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rxr_w[0])
  );

  uart_mmio #(.RX_DEPTH(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .is_uart(is_uart), .mem_addr(mem_addr),
    .byte_offset(byte_offset), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata_w[1]), .tx_data(txd_w[1]),
    .tx_valid(txv_w[1]), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rxr_w[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  int          dep [2];
  logic [31:0] cmsk [2];
  logic [7:0]  m_mem [2][8];
  int          m_head [2];
  int          m_n [2];
  logic        m_txv [2];
  logic [7:0]  m_txd [2];
  logic        m_drp [2];
  logic        m_ovr [2];
  logic [31:0] m_cnt [2];
  logic [31:0] m_rd [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_head[i] = 0; m_n[i] = 0;
      m_txv[i] = 0; m_txd[i] = 0;
      m_drp[i] = 0; m_ovr[i] = 0;
      m_cnt[i] = 0; m_rd[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    logic [7:0]  off;
    logic [31:0] rv;
    bit acc, wr, rd, hs, full, pop, push;
    bit set_drp, set_ovr, clr;
    int tail;
    off  = {mem_addr[7:2], 2'b00};
    acc  = is_uart && byte_offset == 2'b00;
    wr   = acc && wr_en;
    rd   = acc && rd_en && !wr_en;
    hs   = m_txv[i] && tx_ready;
    full = m_n[i] == dep[i];
    if (rd) begin
      case (off)
        8'h00:   rv = {31'b0, !m_txv[i]};
        8'h04:   rv = {31'b0, m_n[i] != 0};
        8'h0C:   rv = (m_n[i] != 0) ? {24'b0, m_mem[i][m_head[i]]} : 0;
        8'h10:   rv = m_cnt[i];
        8'h14:   rv = {30'b0, m_ovr[i], m_drp[i]};
        default: rv = 0;
      endcase
      m_rd[i] = rv;
    end
    set_drp = 0;
    if (wr && off == 8'h08) begin
      if (!m_txv[i] || hs) begin
        m_txv[i] = 1;
        m_txd[i] = wdata[7:0];
      end else set_drp = 1;
    end else if (hs) m_txv[i] = 0;
    pop     = rd && off == 8'h0C && m_n[i] != 0;
    push    = rx_valid && !full;
    set_ovr = rx_valid && full;
    tail    = (m_head[i] + m_n[i]) % dep[i];
    if (pop) begin
      m_head[i] = (m_head[i] + 1) % dep[i];
      m_n[i]--;
    end
    if (push) begin
      m_mem[i][tail] = rx_data;
      m_n[i]++;
    end
    clr = wr && off == 8'h14;
    m_drp[i] = (m_drp[i] && !(clr && wdata[0])) || set_drp;
    m_ovr[i] = (m_ovr[i] && !(clr && wdata[1])) || set_ovr;
    if (wr && off == 8'h10) m_cnt[i] = 0;
    else m_cnt[i] = (m_cnt[i] + 1) & cmsk[i];
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rdata%0d", i), rdata_w[i], m_rd[i]);
      chk($sformatf("txv%0d", i), 32'(txv_w[i]), 32'(m_txv[i]));
      chk($sformatf("txd%0d", i), 32'(txd_w[i]), 32'(m_txd[i]));
      chk($sformatf("rxr%0d", i), 32'(rxr_w[i]), 32'(m_n[i] != dep[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
    #1;
    cmp_all();
  endtask

  task automatic set_acc(input logic [7:0] off);
    is_uart = 1; byte_offset = 0;
    mem_addr = 32'h8000_0000 | 32'(off);
  endtask

  task automatic idle(input int n);
    rd_en = 0; wr_en = 0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic rd(input logic [7:0] off);
    set_acc(off); rd_en = 1; wr_en = 0;
    cycle();
    rd_en = 0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    set_acc(off); wr_en = 1; rd_en = 0; wdata = d;
    cycle();
    wr_en = 0;
  endtask

  logic [7:0] offs [8];

  initial begin
    dep[0] = 8; dep[1] = 4;
    cmsk[0] = 32'hFFFF_FFFF; cmsk[1] = 32'h0000_000F;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h3C};
    model_reset();

    idle(2);
    rst_n = 1;
    chk("rst_rdata", rdata_w[0], 0);
    chk("rst_txv", 32'(txv_w[0]), 0);
    chk("rst_rxr", 32'(rxr_w[0]), 1);
    rd(8'h00); chk("tx_space", rdata_w[0], 1);
    rd(8'h04); chk("rx_avail", rdata_w[0], 0);

    tx_ready = 0;
    wr(8'h08, 32'h0000_0041);
    chk("tx_v", 32'(txv_w[0]), 1);
    chk("tx_d", 32'(txd_w[0]), 32'h41);
    wr(8'h08, 32'h0000_0042);
    chk("tx_keep", 32'(txd_w[0]), 32'h41);
    rd(8'h14); chk("drop_flag", rdata_w[0], 1);
    tx_ready = 1;
    idle(1);
    chk("tx_fall", 32'(txv_w[0]), 0);
    tx_ready = 0;

    wr(8'h14, 3);
    rx_valid = 1;
    for (int k = 1; k <= 8; k++) begin
      rx_data = 8'(k);
      idle(1);
    end
    chk("rx_full", 32'(rxr_w[0]), 0);
    rx_data = 9;
    idle(1);
    rx_valid = 0;
    rd(8'h14); chk("ovr_flag", rdata_w[0], 2);
    for (int k = 1; k <= 8; k++) begin
      rd(8'h0C); chk("rx_order", rdata_w[0], k);
    end
    rd(8'h0C); chk("rx_empty_rd", rdata_w[0], 0);

    rx_valid = 1;
    for (int k = 10; k <= 12; k++) begin
      rx_data = 8'(k);
      idle(1);
    end
    rx_data = 13;
    rd(8'h0C); chk("pushpop", rdata_w[0], 10);
    rx_valid = 0;
    for (int k = 11; k <= 13; k++) begin
      rd(8'h0C); chk("pp_order", rdata_w[0], k);
    end
    rd(8'h04); chk("pp_empty", rdata_w[0], 0);

    wr(8'h10, 32'hDEAD_BEEF);
    idle(5);
    rd(8'h10); chk("cyc5", rdata_w[0], 5);
    wr(8'h10, 0);
    idle(15);
    rd(8'h10); chk("cyc15_s", rdata_w[1], 15);
    rd(8'h10); chk("cyc_wrap_s", rdata_w[1], 0);
    chk("cyc16", rdata_w[0], 16);

    rx_valid = 1;
    rx_data = 8'h55; idle(1);
    rx_data = 8'h66; idle(1);
    rx_valid = 0;
    set_acc(8'h0C); byte_offset = 2'b01; rd_en = 1;
    cycle(); rd_en = 0;
    chk("bo_ignored", rdata_w[0], 16);
    set_acc(8'h0C); is_uart = 0; rd_en = 1;
    cycle(); rd_en = 0;
    chk("nouart_ign", rdata_w[0], 16);
    rd(8'h0C); chk("no_pop", rdata_w[0], 32'h55);

    wr(8'h08, 32'h77);
    chk("tx_pre_rst", 32'(txv_w[0]), 1);
    rst_n = 0;
    #1;
    chk("rst_txv0", 32'(txv_w[0]), 0);
    chk("rst_rxr0", 32'(rxr_w[0]), 1);
    chk("rst_txv1", 32'(txv_w[1]), 0);
    chk("rst_rd0", rdata_w[0], 0);
    model_reset();
    idle(2);
    rst_n = 1;

    for (int n = 0; n < 3000; n++) begin
      is_uart     = ($urandom_range(0, 9) != 0);
      byte_offset = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      mem_addr    = ($urandom & 32'hFFFF_FF00)
                  | 32'(offs[$urandom_range(0, 7)]);
      rd_en       = ($urandom_range(0, 2) == 0);
      wr_en       = ($urandom_range(0, 3) == 0);
      wdata       = $urandom;
      tx_ready    = ($urandom_range(0, 2) == 0);
      rx_valid    = ($urandom_range(0, 2) == 0);
      rx_data     = 8'($urandom);
      rst_n       = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
